// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FPU command issuer.
//   fpu_op_e    : operation encoding driven onto fpu_op_sel / rsp_op
//   iss_state_e : issuer control states
//   fpu_cmd_t   : one queued command (op + two single-precision operands)
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } iss_state_e;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef struct packed {
    fpu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } fpu_cmd_t;

  localparam int CMD_W = $bits(fpu_cmd_t);  // 66

  // Last wait-counter value before the issuer gives up on the FPU.
  function automatic logic [7:0] wait_limit(input int timeout);
    return 8'(timeout - 1);
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the issuer.
//   clk, reset   : clock, async active-low reset (clears pointers and storage)
//   push, wdata  : write port, ignored while full
//   pop, rdata   : read port, rdata shows the head entry, pop ignored while empty
//   full, empty  : status from the wrapping pointer comparison
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en, rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/fpu_issuer.sv
// Queues FPU commands and issues them one at a time to an external FPU,
// collecting each result (or a timeout abort) as an in-order response.
//   clk, reset                  : clock, async active-low reset
//   cmd_valid/ready, cmd_op/a/b : command intake into the FIFO
//   fpu_din1/din2/op_sel        : operands/op held from issue until the result
//   fpu_valid                   : one-cycle issue strobe
//   fpu_result, fpu_ready       : FPU return, only looked at while waiting
//   rsp_valid/ready, rsp_*      : response held until consumed
//   busy                        : work queued or in flight
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic [1:0]  fpu_op_sel,
  output logic        fpu_valid,
  input  logic [31:0] fpu_result,
  input  logic        fpu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam logic [7:0] WAIT_LAST = wait_limit(TIMEOUT);

  iss_state_e state;
  fpu_cmd_t   wr_cmd, head;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [7:0] wait_cnt;

  assign wr_cmd = '{op: fpu_op_e'(cmd_op), a: cmd_a, b: cmd_b};

  // No bypass: a full FIFO refuses even when it is being popped this cycle.
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & ~fifo_full;
  // The head leaves the FIFO on the same edge that loads the FPU operands.
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  fpu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      fpu_din1    <= '0;
      fpu_din2    <= '0;
      fpu_op_sel  <= '0;
      fpu_valid   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      fpu_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fpu_din1   <= head.a;
            fpu_din2   <= head.b;
            fpu_op_sel <= head.op;
            fpu_valid  <= 1'b1;   // high for exactly the ISSUE cycle
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (fpu_ready) begin
            rsp_data    <= fpu_result;
            rsp_op      <= fpu_op_sel;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_data    <= '0;
            rsp_op      <= fpu_op_sel;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issuer.sv
module tb_fpu_issuer;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        cmd_valid, cmd_ready, fpu_valid, fpu_ready;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [1:0]  cmd_op, fpu_op_sel, rsp_op;
  logic [31:0] cmd_a, cmd_b, fpu_din1, fpu_din2, fpu_result, rsp_data;

  always #5 clk = ~clk;

  fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_op_sel(fpu_op_sel),
    .fpu_valid(fpu_valid), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;    // cycle of acceptance
    bit          fresh;  // accepted with nothing queued or in flight
  } tcmd_t;

  int    checks = 0, failures = 0, cyc = 0;
  tcmd_t src_q[$], wq[$];   // not yet offered/accepted, accepted/not yet issued
  tcmd_t cur;
  bit    inflight = 0, rsp_due = 0, stall = 0, issue_next = 0, spur_all = 0;
  bit    force_en = 0, exp_to = 0;
  int    k = 0, lat = 0, lat_fixed = -1, issue_cyc = 0, rsp_cyc = 0;
  int    rsp_hold = 0, rdy_pct = 100, gap_pct = 0, n_rsp = 0;
  logic [31:0] exp_data = '0, force_val = '0, last_data = '0;
  logic        last_to = 1'b0;
  logic [1:0]  last_op = '0;

  // Stand-in FPU arithmetic: any deterministic function of the command works.
  function automatic logic [31:0] fmodel(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return a ^ {b[7:0], b[31:8]};
    endcase
  endfunction

  function automatic tcmd_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    tcmd_t t;
    t.op = op; t.a = a; t.b = b; t.acc = 0; t.fresh = 0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: observe the DUT just after the edge, compare with the model,
  // then drive inputs for the coming edge and advance the model.
  task automatic tick();
    bit exp_rv, hs;
    @(posedge clk); #1; cyc++;

    chk("fpu_valid", 32'(fpu_valid), 32'(issue_next));
    if (fpu_valid && wq.size() > 0) begin
      cur = wq.pop_front();
      if (cur.fresh) chk("issue_lat", 32'(cyc - cur.acc), 32'd2);
      inflight = 1; rsp_due = 0; k = 0; issue_cyc = cyc;
      lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(1, TMO + 2));
    end else if (inflight) k++;

    if (inflight && !rsp_due) begin
      chk("din1", fpu_din1, cur.a);
      chk("din2", fpu_din2, cur.b);
      chk("op_sel", 32'(fpu_op_sel), 32'(cur.op));
    end

    exp_rv = inflight && rsp_due && (cyc >= rsp_cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv && rsp_valid) begin
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_op", 32'(rsp_op), 32'(cur.op));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      if (exp_to && cyc == rsp_cyc) chk("tmo_lat", 32'(cyc - issue_cyc), 32'(TMO + 1));
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(wq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(wq.size() > 0 || inflight));
    issue_next = !inflight && wq.size() > 0;

    // response consumer
    if (rsp_hold > 0) begin rsp_ready = 1'b0; rsp_hold--; end
    else rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    hs = exp_rv && rsp_ready;
    if (hs) begin last_data = rsp_data; last_to = rsp_timeout; last_op = rsp_op; n_rsp++; end

    // command producer
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = $urandom; cmd_b = $urandom;
    if (src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      cmd_valid = 1'b1; cmd_op = src_q[0].op; cmd_a = src_q[0].a; cmd_b = src_q[0].b;
      if (wq.size() < DEPTH) begin
        tcmd_t t = src_q.pop_front();
        t.acc = cyc; t.fresh = (!inflight || hs) && wq.size() == 0;
        wq.push_back(t);
      end
    end

    // FPU: WAIT is the k = 1..TMO window after the issue cycle
    fpu_ready = 1'b0; fpu_result = $urandom;
    if (inflight && !rsp_due && k >= 1) begin
      if (!stall && k >= lat) begin
        fpu_ready = 1'b1;
        fpu_result = force_en ? force_val : fmodel(cur.op, cur.a, cur.b);
        exp_data = fpu_result; exp_to = 0; rsp_due = 1; rsp_cyc = cyc + 1;
      end else if (k == TMO) begin
        exp_data = '0; exp_to = 1; rsp_due = 1; rsp_cyc = cyc + 1;
      end
    end else begin
      // outside WAIT the issuer must ignore whatever the FPU says
      fpu_ready = spur_all || ($urandom_range(0, 3) == 0);
    end
    if (hs) begin inflight = 0; rsp_due = 0; end
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((src_q.size() > 0 || wq.size() > 0 || inflight) && n < max) begin tick(); n++; end
    chk("drain", 32'(src_q.size() + wq.size() + int'(inflight)), 32'd0);
  endtask

  initial begin
    int n0, n;
    tcmd_t c;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
    fpu_ready = 0; fpu_result = 0; rsp_ready = 0;

    // reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_fpu_valid", 32'(fpu_valid), 0);
    chk("rst_din1", fpu_din1, 0);
    chk("rst_din2", fpu_din2, 0);
    chk("rst_op_sel", 32'(fpu_op_sel), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_op", 32'(rsp_op), 0);
    chk("rst_rsp_to", 32'(rsp_timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    #1 chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // 1.0 + 2.0 with a 3-cycle FPU
    lat_fixed = 3; force_en = 1; force_val = 32'h4040_0000;
    src_q.push_back(mk(2'b00, 32'h3F80_0000, 32'h4000_0000));
    run_idle(100);
    chk("add_data", last_data, 32'h4040_0000);
    chk("add_op", 32'(last_op), 0);
    chk("add_to", 32'(last_to), 0);
    force_en = 0;

    // FIFO fills behind a stalled FPU, then drains in order
    stall = 1; lat_fixed = 2; rsp_hold = 30; gap_pct = 0; n0 = n_rsp;
    src_q.push_back(mk(2'($urandom), $urandom, $urandom));
    repeat (3) tick();
    for (int i = 0; i < 5; i++) src_q.push_back(mk(2'($urandom), $urandom, $urandom));
    repeat (5) tick();
    chk("fifth_blocked", 32'(cmd_ready), 0);
    stall = 0; rsp_hold = 0;
    run_idle(400);
    chk("stall_rsp_cnt", 32'(n_rsp - n0), 32'd6);

    // FPU never answers: abort after the full window, next command follows
    lat_fixed = 99;
    src_q.push_back(mk(2'b01, $urandom, $urandom));
    src_q.push_back(mk(2'b10, $urandom, $urandom));
    run_idle(200);
    chk("tmo_flag", 32'(last_to), 1);
    chk("tmo_data", last_data, 0);
    chk("tmo_op", 32'(last_op), 32'd2);

    // result on the very last WAIT cycle beats the timeout
    lat_fixed = TMO;
    c = mk(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    src_q.push_back(c);
    run_idle(200);
    chk("coinc_to", 32'(last_to), 0);
    chk("coinc_data", last_data, fmodel(c.op, c.a, c.b));

    // consumer holds off: response stays put and nothing else issues
    lat_fixed = 1; rsp_hold = 16;
    for (int i = 0; i < 3; i++) src_q.push_back(mk(2'($urandom), $urandom, $urandom));
    run_idle(300);

    // random traffic
    lat_fixed = -1; rdy_pct = 60; gap_pct = 30;
    for (int i = 0; i < 150; i++) src_q.push_back(mk(2'($urandom), $urandom, $urandom));
    run_idle(6000);

    // reset while waiting with three queued, then a stray fpu_ready
    rdy_pct = 100; gap_pct = 0; stall = 1; lat_fixed = 2;
    for (int i = 0; i < 4; i++) src_q.push_back(mk(2'($urandom), $urandom, $urandom));
    n = 0;
    while (!(inflight && wq.size() == 3 && k >= 2) && n < 50) begin tick(); n++; end
    chk("mid_queued", 32'(wq.size()), 32'd3);
    reset = 1'b0;
    src_q.delete(); wq.delete();
    inflight = 0; rsp_due = 0; issue_next = 0; stall = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_fpu_valid", 32'(fpu_valid), 0);
    repeat (2) tick();
    reset = 1'b1; spur_all = 1; n0 = n_rsp;
    repeat (6) tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_rsp_cnt", 32'(n_rsp - n0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
